// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns the core's single-cycle data access into a req/addr_ok/data_ok
// memory handshake, stalling the core until completion, with a watchdog for hung accesses.
module data_sram_bridge #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    state_t           state_q, state_d;
    logic [29:0]      addr_q, addr_d;
    logic [3:0]       wen_q, wen_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;
    logic             busy, done, expire;

    assign busy = state_q == ADDR || state_q == DATA;
    assign done = (state_q == ADDR && mem_addr_ok && mem_data_ok) || (state_q == DATA && mem_data_ok);
    // Completion in the last watchdog cycle wins over the timeout.
    assign expire = busy && !done && wd_q == WD_LAST;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wd_d    = busy ? wd_q + 1'b1 : '0;
        err_d   = err_q | expire;
        rdata_d = expire ? '0 : (done && wen_q == 4'b0000) ? mem_rdata : rdata_q;
        case (state_q)
            IDLE: if (cpu_en) begin
                state_d = ADDR;
                addr_d  = cpu_addr[31:2];
                wen_d   = cpu_wen;
                wdata_d = cpu_wdata;
            end
            ADDR:    state_d = (done || expire) ? HOLD : mem_addr_ok ? DATA : ADDR;
            DATA:    state_d = (done || expire) ? HOLD : DATA;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    assign cpu_stall = (state_q == IDLE && cpu_en) || busy;
    assign mem_req   = state_q == ADDR;
    assign mem_wr    = |wen_q;
    assign mem_wstrb = wen_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign cpu_rdata = rdata_q;
    assign bus_err   = err_q;
endmodule
